// File: rtl/regfile_sb.sv
// +--------------------------------------------------------------------------+
// | Module   : regfile_sb                                                    |
// | Brief    : RV32I integer register file, NUM_RD read ports, one write     |
// |            port and a per-register busy scoreboard for RAW stalls.       |
// |            Optional WB->ID forwarding when REGFILE_BYPASS_EN is defined. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       set_busy,
  input  logic [ADDR_W-1:0]          set_addr,
  output logic                       busy_any
);

  localparam int c_NUM_REGS = 2 ** ADDR_W;

  // x0 has no storage; arrays start at index 1.
  logic [DATA_W-1:0]     regs_q [1:c_NUM_REGS-1];
  logic [c_NUM_REGS-1:1] busy_q;
  logic [c_NUM_REGS-1:1] busy_d;
  logic                  w_wr_en;
  logic                  w_set_en;

  assign w_wr_en  = we && (waddr != '0);
  assign w_set_en = set_busy && (set_addr != '0);

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < c_NUM_REGS; r++) begin
      if (w_wr_en && (waddr == ADDR_W'(r))) busy_d[r] = 1'b0;
      if (w_set_en && (set_addr == ADDR_W'(r))) busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int r = 1; r < c_NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int r = 1; r < c_NUM_REGS; r++) begin
        if (w_wr_en && (waddr == ADDR_W'(r))) regs_q[r] <= wdata;
      end
    end
  end

  assign busy_any = !rst && (|busy_q);

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_sel;
      logic [DATA_W-1:0] w_stored;
      logic              w_busy;

      assign w_addr = raddr[p*ADDR_W +: ADDR_W];
      assign w_sel  = re[p] && (w_addr != '0);

      always_comb begin
        w_stored = '0;
        w_busy   = 1'b0;
        for (int r = 1; r < c_NUM_REGS; r++) begin
          if (w_addr == ADDR_W'(r)) begin
            w_stored = regs_q[r];
            w_busy   = busy_q[r];
          end
        end
      end

`ifdef REGFILE_BYPASS_EN
      logic w_fwd;
      // w_sel already excludes x0, so a forwarded write is never to x0.
      assign w_fwd = w_sel && we && (waddr == w_addr);
      assign rdata[p*DATA_W +: DATA_W] = (rst || !w_sel) ? '0 : (w_fwd ? wdata : w_stored);
      assign rbusy[p] = !rst && w_sel && w_busy && !w_fwd;
`else
      assign rdata[p*DATA_W +: DATA_W] = (rst || !w_sel) ? '0 : w_stored;
      assign rbusy[p] = !rst && w_sel && w_busy;
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_sb                                                 |
// | Brief    : Directed + random bench for regfile_sb against an array model.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NR-1:0]     re;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              set_busy;
  logic [AW-1:0]     set_addr;
  logic              busy_any;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] m_regs [NREG];
  bit            m_busy [NREG];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .set_busy(set_busy), .set_addr(set_addr), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int ra(input int p);
    return int'(raddr[p*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input int p);
    int a = ra(p);
    if (rst || !re[p] || a == 0) return '0;
    if (BYP && we && int'(waddr) == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic bit exp_rbusy(input int p);
    int a = ra(p);
    if (rst || !re[p] || a == 0) return 1'b0;
    if (BYP && we && int'(waddr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit exp_busy_any();
    bit any = 1'b0;
    for (int r = 1; r < NREG; r++) any |= m_busy[r];
    return !rst && any;
  endfunction

  // Move to mid-cycle and compare every output against the model.
  task automatic settle();
    #4;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rdata%0d", p), 64'(rd(p)), 64'(exp_rdata(p)));
      check($sformatf("rbusy%0d", p), 64'(rbusy[p]), 64'(exp_rbusy(p)));
    end
    check("busy_any", 64'(busy_any), 64'(exp_busy_any()));
  endtask

  // Apply this cycle's inputs to the model, then cross the clock edge.
  task automatic advance();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (we && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (set_busy && set_addr != 0) m_busy[set_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    set_busy = 0; set_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
    re[p] = 1'b1;
  endtask

  initial begin
    idle();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1;
    settle(); advance();

    // Reset: fill every register, mark some busy, then reset.
    for (int r = 1; r < NREG; r++) begin
      idle();
      we = 1; waddr = AW'(r); wdata = $urandom;
      set_busy = (r % 3 == 0); set_addr = AW'(NREG - r);
      settle(); advance();
    end
    idle();
    rst = 1; set_rd(0, 5); set_rd(1, 31); set_rd(2, 1);
    settle();
    check("t1_rst_rd0", 64'(rd(0)), 64'h0);
    check("t1_rst_busy_any", 64'(busy_any), 64'h0);
    advance();
    idle();
    set_rd(0, 5);
    settle();
    check("t1_x5_after_rst", 64'(rd(0)), 64'h0);
    advance();

    // x0 ignores writes and busy marking.
    idle();
    we = 1; waddr = '0; wdata = 32'hDEADBEEF;
    settle(); advance();
    idle();
    set_rd(0, 0); set_busy = 1; set_addr = '0;
    settle();
    check("t2_x0_rd", 64'(rd(0)), 64'h0);
    advance();
    idle();
    set_rd(0, 0);
    settle();
    check("t2_x0_rbusy", 64'(rbusy[0]), 64'h0);
    check("t2_busy_any", 64'(busy_any), 64'h0);
    advance();

    // Multi-port reads with shared addresses.
    idle(); we = 1; waddr = 5'd3; wdata = 32'h1234;
    settle(); advance();
    idle(); we = 1; waddr = 5'd7; wdata = 32'hFFFF_0001;
    settle(); advance();
    idle(); set_rd(0, 3); set_rd(1, 7); set_rd(2, 3);
    settle();
    check("t3_p0", 64'(rd(0)), 64'h1234);
    check("t3_p1", 64'(rd(1)), 64'hFFFF_0001);
    check("t3_p2", 64'(rd(2)), 64'h1234);
    re[1] = 1'b0;
    settle();
    check("t3_p1_disabled", 64'(rd(1)), 64'h0);
    advance();

    // Scoreboard around a writeback.
    idle(); set_busy = 1; set_addr = 5'd10; set_rd(0, 10);
    settle();
    check("t4_same_cycle_set", 64'(rbusy[0]), 64'h0);
    advance();
    idle(); set_rd(0, 10);
    settle();
    check("t4_rbusy", 64'(rbusy[0]), 64'h1);
    check("t4_busy_any", 64'(busy_any), 64'h1);
    advance();
    idle(); set_rd(0, 10); we = 1; waddr = 5'd10; wdata = 32'h55;
    settle();
    check("t4_wb_rdata", 64'(rd(0)), BYP ? 64'h55 : 64'h0);
    check("t4_wb_rbusy", 64'(rbusy[0]), BYP ? 64'h0 : 64'h1);
    advance();
    idle(); set_rd(0, 10);
    settle();
    check("t4_after_rdata", 64'(rd(0)), 64'h55);
    check("t4_after_rbusy", 64'(rbusy[0]), 64'h0);
    advance();

    // Set and clear on the same register: set wins.
    idle(); set_busy = 1; set_addr = 5'd4;
    settle(); advance();
    idle(); set_busy = 1; set_addr = 5'd4; we = 1; waddr = 5'd4; wdata = 32'd9;
    settle(); advance();
    idle(); set_rd(1, 4);
    settle();
    check("t5_rdata", 64'(rd(1)), 64'd9);
    check("t5_rbusy", 64'(rbusy[1]), 64'h1);
    advance();

    // Reset beats a concurrent writeback.
    idle(); set_busy = 1; set_addr = 5'd12;
    settle(); advance();
    idle(); rst = 1; we = 1; waddr = 5'd12; wdata = 32'hABC;
    settle(); advance();
    idle(); set_rd(2, 12); set_rd(0, 4);
    settle();
    check("t6_rdata", 64'(rd(2)), 64'h0);
    check("t6_rbusy", 64'(rbusy[2]), 64'h0);
    check("t6_busy_any", 64'(busy_any), 64'h0);
    advance();

    // Random traffic on a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      idle();
      rst      = ($urandom_range(0, 49) == 0);
      we       = $urandom_range(0, 1);
      waddr    = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      wdata    = $urandom;
      set_busy = ($urandom_range(0, 2) == 0);
      set_addr = AW'($urandom_range(0, 7));
      re       = NR'($urandom);
      for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
      settle(); advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
